// File: rtl/stage_fetch1_pkg.sv
// ============================================================================
// Module      : stage_fetch1_pkg
// Description : Shared types and widths for the second fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_fetch1_pkg;

  localparam int unsigned FE1_PC_W   = 30;
  localparam int unsigned FE1_INSN_W = 32;

  typedef enum logic [1:0] {
    FE1_IDLE  = 2'd0,
    FE1_WAIT  = 2'd1,
    FE1_HOLD  = 2'd2,
    FE1_DRAIN = 2'd3
  } fe1_state_t;

endpackage

`default_nettype wire

// File: rtl/stage_fetch1.sv
// ============================================================================
// Module      : stage_fetch1
// Description : Second fetch stage: tracks the outstanding I-cache request,
//               presents insn/PC/fault to decode, holds on decode stall,
//               drains on flush and times out hung accesses.
//               Optional FE1_STATS_EN adds three 32-bit event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_fetch1
  import stage_fetch1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_core,
  input  logic                  reset_n,
  input  logic                  fe0_valid,
  input  logic [FE1_PC_W-1:0]   fe0_pc,
  output logic                  fe1_busy,
  input  logic                  ic_rvalid,
  input  logic [FE1_INSN_W-1:0] ic_rdata,
  input  logic                  ic_fault,
  output logic                  ic_abort,
  input  logic                  de_stall,
  input  logic                  de_setpc,
  input  logic                  csr_kill,
  output logic                  fe1_valid,
  output logic                  fe1_stall,
  output logic                  fe1_exc,
  output logic [FE1_PC_W-1:0]   fe1_pc,
  output logic [FE1_INSN_W-1:0] fe1_insn
`ifdef FE1_STATS_EN
  ,
  output logic [31:0]           fe1_stat_insns,
  output logic [31:0]           fe1_stat_miss_cycles,
  output logic [31:0]           fe1_stat_timeouts
`endif
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fe1_state_t              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [FE1_PC_W-1:0]     pc_q;
  logic [FE1_INSN_W-1:0]   insn_q;
  logic                    exc_q;

  logic                    in_wait;
  logic                    in_hold;
  logic                    in_drain;
  logic                    flush;
  logic                    tmo;
  logic                    resp;
  logic                    resp_fault;
  logic [FE1_INSN_W-1:0]   resp_insn;
  logic                    accept;

  assign in_wait    = (state_q == FE1_WAIT);
  assign in_hold    = (state_q == FE1_HOLD);
  assign in_drain   = (state_q == FE1_DRAIN);
  assign flush      = de_setpc | csr_kill;
  assign cnt_d      = cnt_q + CNT_W'(1);

  // A timeout stands in for a faulting response on the cycle it fires.
  assign tmo        = (in_wait | in_drain) & ~ic_rvalid & (cnt_q == CNT_LAST);
  assign resp       = in_wait & (ic_rvalid | tmo);
  assign resp_fault = ic_rvalid ? ic_fault : 1'b1;
  assign resp_insn  = resp_fault ? '0 : ic_rdata;

  assign fe1_busy   = flush | in_drain
                    | (in_wait & ~(resp & ~de_stall))
                    | (in_hold & de_stall);
  assign accept     = fe0_valid & ~fe1_busy & ~flush;

  assign ic_abort   = tmo;
  assign fe1_valid  = in_wait | in_hold;
  assign fe1_stall  = in_wait & ~resp;
  assign fe1_exc    = in_hold ? exc_q : (resp & resp_fault);
  assign fe1_insn   = resp ? resp_insn : insn_q;
  assign fe1_pc     = pc_q;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FE1_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      insn_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      case (state_q)
        FE1_IDLE: ;
        FE1_WAIT: begin
          if (flush) begin
            if (resp) begin
              state_q <= FE1_IDLE;
            end else begin
              state_q <= FE1_DRAIN;
              cnt_q   <= cnt_d;
            end
          end else if (resp) begin
            if (de_stall) begin
              state_q <= FE1_HOLD;
              insn_q  <= resp_insn;
              exc_q   <= resp_fault;
            end else begin
              state_q <= FE1_IDLE;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        FE1_HOLD: begin
          if (flush || !de_stall) begin
            state_q <= FE1_IDLE;
          end
        end
        FE1_DRAIN: begin
          if (ic_rvalid || tmo) begin
            state_q <= FE1_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= FE1_IDLE;
      endcase

      // Accept is only possible when the slot empties this cycle, so it
      // overrides whatever transition the case above chose.
      if (accept) begin
        state_q <= FE1_WAIT;
        pc_q    <= fe0_pc;
        cnt_q   <= '0;
        insn_q  <= '0;
        exc_q   <= 1'b0;
      end
    end
  end

`ifdef FE1_STATS_EN
  logic handoff;
  assign handoff = fe1_valid & ~fe1_stall & ~de_stall;

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      fe1_stat_insns       <= '0;
      fe1_stat_miss_cycles <= '0;
      fe1_stat_timeouts    <= '0;
    end else begin
      if (handoff && !fe1_exc) fe1_stat_insns <= fe1_stat_insns + 32'd1;
      if (in_wait && fe1_stall) fe1_stat_miss_cycles <= fe1_stat_miss_cycles + 32'd1;
      if (ic_abort) fe1_stat_timeouts <= fe1_stat_timeouts + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_stage_fetch1.sv
// ============================================================================
// Module      : tb_stage_fetch1
// Description : Randomized self-checking bench for stage_fetch1 with an
//               I-cache responder and a slot-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_fetch1;

  localparam int unsigned TMO    = 8;
  localparam int          N_CYC  = 4000;

  logic        clk_core = 1'b0;
  logic        reset_n;
  logic        fe0_valid;
  logic [29:0] fe0_pc;
  logic        fe1_busy;
  logic        ic_rvalid;
  logic [31:0] ic_rdata;
  logic        ic_fault;
  logic        ic_abort;
  logic        de_stall;
  logic        de_setpc;
  logic        csr_kill;
  logic        fe1_valid;
  logic        fe1_stall;
  logic        fe1_exc;
  logic [29:0] fe1_pc;
  logic [31:0] fe1_insn;

  stage_fetch1 #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_core  (clk_core),
    .reset_n   (reset_n),
    .fe0_valid (fe0_valid),
    .fe0_pc    (fe0_pc),
    .fe1_busy  (fe1_busy),
    .ic_rvalid (ic_rvalid),
    .ic_rdata  (ic_rdata),
    .ic_fault  (ic_fault),
    .ic_abort  (ic_abort),
    .de_stall  (de_stall),
    .de_setpc  (de_setpc),
    .csr_kill  (csr_kill),
    .fe1_valid (fe1_valid),
    .fe1_stall (fe1_stall),
    .fe1_exc   (fe1_exc),
    .fe1_pc    (fe1_pc),
    .fe1_insn  (fe1_insn)
  );

  always #5 clk_core = ~clk_core;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference slot: an instruction slot that is either waiting for data or
  // already holding it, plus a flag for a cancelled request still in flight.
  bit          m_full, m_ready, m_exc, m_discard;
  logic [29:0] m_pc;
  logic [31:0] m_insn;
  int          m_waited;

  // I-cache responder
  bit c_pending;
  int c_delay;

  function automatic void model_clear();
    m_full = 0; m_ready = 0; m_exc = 0; m_discard = 0;
    m_pc = '0; m_insn = '0; m_waited = 0;
    c_pending = 0; c_delay = 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(fe1_valid), 32'd0);
    check_eq({tag, "_stall"}, 32'(fe1_stall), 32'd0);
    check_eq({tag, "_exc"},   32'(fe1_exc),   32'd0);
    check_eq({tag, "_abort"}, 32'(ic_abort),  32'd0);
    check_eq({tag, "_busy"},  32'(fe1_busy),  32'd0);
    check_eq({tag, "_pc"},    32'(fe1_pc),    32'd0);
    check_eq({tag, "_insn"},  fe1_insn,       32'd0);
  endtask

  task automatic quiet_inputs();
    fe0_valid = 0; fe0_pc = '0; ic_rvalid = 0; ic_rdata = '0; ic_fault = 0;
    de_stall = 0; de_setpc = 0; csr_kill = 0;
  endtask

  initial begin
    bit   flush, waiting, tmo, resp, flt, have, e_stall, e_busy, acc;
    logic [31:0] e_insn;
    int   r;

    reset_n = 1'b0;
    quiet_inputs();
    model_clear();
    repeat (3) @(negedge clk_core);
    #1 check_reset_outputs("por");
    reset_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk_core);

      // Occasional async reset between edges, while busy or idle.
      if ($urandom_range(0, 149) == 0) begin
        quiet_inputs();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("arst");
        @(negedge clk_core);
        reset_n = 1'b1;
        model_clear();
        continue;
      end

      fe0_valid = ($urandom_range(0, 3) != 0);
      fe0_pc    = 30'($urandom);
      de_stall  = ($urandom_range(0, 2) == 0);
      r         = $urandom_range(0, 39);
      de_setpc  = (r == 0);
      csr_kill  = (r == 1);
      ic_rdata  = $urandom;
      ic_fault  = ($urandom_range(0, 5) == 0);
      if (c_pending) ic_rvalid = (c_delay == 0);
      else           ic_rvalid = ($urandom_range(0, 7) == 0);

      #1;
      flush   = de_setpc | csr_kill;
      waiting = m_full & !m_ready;
      tmo     = (waiting | m_discard) & !ic_rvalid & (m_waited == TMO - 1);
      resp    = waiting & (ic_rvalid | tmo);
      flt     = ic_rvalid ? ic_fault : 1'b1;
      have    = m_ready | resp;
      e_stall = waiting & !resp;
      e_busy  = flush | m_discard | (m_full & !(have & !de_stall));
      acc     = fe0_valid & !e_busy;
      e_insn  = m_ready ? m_insn : (flt ? 32'd0 : ic_rdata);

      check_eq("valid", 32'(fe1_valid), 32'(m_full));
      check_eq("stall", 32'(fe1_stall), 32'(e_stall));
      check_eq("exc",   32'(fe1_exc),   32'(m_full & have & (m_ready ? m_exc : flt)));
      check_eq("abort", 32'(ic_abort),  32'(tmo));
      check_eq("busy",  32'(fe1_busy),  32'(e_busy));
      if (m_full) check_eq("pc", 32'(fe1_pc), 32'(m_pc));
      if (m_full && have) check_eq("insn", fe1_insn, e_insn);

      // Slot bookkeeping for the coming clock edge.
      if (m_discard) begin
        if (ic_rvalid || tmo) m_discard = 0;
        else                  m_waited++;
      end else if (flush) begin
        if (waiting && !resp) begin
          m_discard = 1;
          m_waited++;
        end
        m_full = 0;
      end else if (m_full) begin
        if (have && !de_stall) m_full = 0;
        else if (resp) begin
          m_ready = 1;
          m_exc   = flt;
          m_insn  = flt ? 32'd0 : ic_rdata;
        end else m_waited++;
      end
      if (acc) begin
        m_full = 1; m_ready = 0; m_pc = fe0_pc; m_waited = 0;
      end

      // Cache side: retire or count down, then schedule the new request.
      if (c_pending) begin
        if (ic_rvalid || tmo) c_pending = 0;
        else                  c_delay--;
      end
      if (acc) begin
        r = $urandom_range(0, 9);
        c_pending = 1;
        c_delay   = ((r < 6) ? (1 + r % 3) : $urandom_range(1, 12)) - 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stage_fetch1.md
Name: stage_fetch1

Overview:
Second fetch stage. It sits between fetch0, which issues the PC and the I-cache request, and decode.
- Tracks the single outstanding I-cache request and presents the returned instruction, its PC, and any fetch fault to decode using the fe1_valid/fe1_stall/fe1_exc protocol.
- Holds the instruction while decode stalls.
- Discards in-flight responses on redirect or kill.
- Times out a hung cache access into a fetch fault.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without a response before a synthesized fault (1..1023).

Ports:
clk_core  in  1  core clock
reset_n  in  1  asynchronous active-low reset
fe0_valid  in  1  fetch0 has an issued request this cycle
fe0_pc  in  30  [31:2] PC of that request
fe1_busy  out  1  fetch0 must hold its request and not issue a new one
ic_rvalid  in  1  I-cache response valid
ic_rdata  in  32  instruction word
ic_fault  in  1  access fault for this response
ic_abort  out  1  single-cycle pulse: cache must drop the outstanding request
de_stall  in  1  decode not accepting
de_setpc  in  1  redirect from decode/execute; flush
csr_kill  in  1  trap/kill; flush
fe1_valid  out  1  stage holds an instruction slot
fe1_stall  out  1  slot valid but data not yet returned
fe1_exc  out  1  fetch fault for this slot
fe1_pc  out  30  [31:2] PC of slot
fe1_insn  out  32  instruction; 0 when fe1_exc

Behaviour:
- Reset is async and active-low. On reset: state=IDLE, fe1_valid=fe1_stall=fe1_exc=ic_abort=0, fe1_pc=0, fe1_insn=0, timeout counter=0.
- flush = de_setpc | csr_kill. handoff = fe1_valid & ~fe1_stall & ~de_stall.
- Accept condition: fe0_valid & ~fe1_busy & ~flush. On accept, latch fe0_pc, enter WAIT, clear the counter.
- The cache returns at most one response per accepted request, in order, with ic_rvalid no earlier than the cycle after accept.
- IDLE:
  - fe1_valid=0, fe1_busy=0.
  - Stray ic_rvalid is ignored.
- WAIT:
  - fe1_valid=1.
  - fe1_stall=~ic_rvalid.
  - On ic_rvalid, bypass combinationally: fe1_insn=ic_fault?0:ic_rdata, fe1_exc=ic_fault.
  - If the response arrives with ~de_stall, handoff occurs this cycle. The next state is WAIT if a new request is accepted in the same cycle, else IDLE. This gives one instruction per cycle with a 1-cycle cache.
  - If the response arrives with de_stall, register insn/exc and go to HOLD.
  - Counter increments every WAIT cycle without ic_rvalid. On reaching TIMEOUT_CYCLES:
    - pulse ic_abort;
    - treat the cycle as a response with fault=1: fe1_stall=0, fe1_exc=1, fe1_insn=0;
    - handoff or HOLD as above.
- HOLD:
  - fe1_valid=1, fe1_stall=0, outputs come from registers.
  - On ~de_stall, handoff; accept a new request in the same cycle if offered.
- DRAIN:
  - fe1_valid=0, fe1_busy=1.
  - The next ic_rvalid is discarded, then go to IDLE.
  - Counter runs. On timeout, pulse ic_abort and go to IDLE.
- fe1_busy = flush | DRAIN | (WAIT & ~(resp & ~de_stall)) | (HOLD & de_stall), where resp = ic_rvalid | timeout.
- Flush has the highest priority:
  - in WAIT with no resp this cycle: go to DRAIN;
  - in WAIT with resp, or in HOLD: go to IDLE, and the response/insn is dropped;
  - fe0_valid is ignored in the flush cycle.
- The flush-cycle outputs are unchanged, because decode itself discards on csr_kill and on redirect.
- fe1_exc is asserted only with fe1_valid & ~fe1_stall.
- Reset asserted mid-operation returns to IDLE immediately. The I-cache is reset by the same reset_n.

Optional Feature:
FE1_STATS_EN.
- When defined, adds three 32-bit outputs, each wrapping at 2^32 and reset to 0 by reset_n:
  - fe1_stat_insns: handoffs with ~fe1_exc;
  - fe1_stat_miss_cycles: cycles in WAIT with fe1_stall=1;
  - fe1_stat_timeouts: ic_abort pulses.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Add fe1_state_t (IDLE, WAIT, HOLD, DRAIN; 2-bit enum) to the shared defines package.
- The timeout counter width is $clog2(TIMEOUT_CYCLES+1) and stays local.
- No sub-module: the FSM, counter and hold registers are inline, roughly 150–250 lines.

Test Plan:
- Back-to-back hits: fe0 PCs 0x100, 0x104, 0x108 with ic_rvalid 1 cycle after each accept and de_stall=0 → three handoffs on consecutive cycles, fe1_pc[31:2]=0x40/0x41/0x42, fe1_busy never high.
- Decode stall: response 0x00500093 arrives with de_stall=1 for 3 cycles → HOLD; fe1_insn is held and fe1_busy=1 for 3 cycles; handoff on the 4th cycle; a new fe0 is accepted in the same cycle.
- Miss then fault: 5-cycle miss → fe1_stall=1 for 4 cycles; response with ic_fault=1 → fe1_exc=1, fe1_insn=0, fe1_stall=0 in that cycle.
- Redirect mid-miss: de_setpc in cycle 2 of WAIT, response in cycle 4 → DRAIN, response discarded, fe1_valid=0 throughout; the next fe0 is accepted in cycle 5.
- Timeout: TIMEOUT_CYCLES=8, no response → ic_abort pulses exactly once at the 8th WAIT cycle, fe1_exc=1 in the same cycle, and a later stray ic_rvalid in IDLE is ignored.
- Async reset asserted in HOLD between clock edges → all outputs 0 immediately; after release, the first fe0 request behaves as from reset.
